// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: arbiter FSM states, command encoding and default widths.
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Index width for a master count; never zero so single-bit selects stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping at N_MASTERS-1.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int N_MASTERS = 2,
    localparam int IDX_W = idx_w(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 gnt_valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = rr_ptr_i;
        // Explicit wrap keeps the walk inside 0..N_MASTERS-1 for non-power-of-2 counts.
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_idx_o   = idx;
                gnt_valid_o = 1'b1;
            end
            idx = (idx == IDX_W'(N_MASTERS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave crossbar arbiter: round-robin grant, one outstanding transaction, responses routed to the granted master.
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_cmd,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_resp,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic                          s_req,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_cmd,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic                          s_ack,
    input  logic                          s_resp,
    input  logic [DATA_W-1:0]             s_rdata
);

    localparam int IDX_W = idx_w(N_MASTERS);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             sel_req;
    logic             sel_cmd;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N_MASTERS - 1)) ? '0 : v + IDX_W'(1);
    endfunction

    rr_arbiter #(
        .N_MASTERS (N_MASTERS)
    ) u_rr_arbiter (
        .req_i       (m_req),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign sel_req = m_req[gnt_q];
    assign sel_cmd = m_cmd[gnt_q];

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        s_req    = 1'b0;
        s_addr   = '0;
        s_cmd    = 1'b0;
        s_wdata  = '0;
        m_ack    = '0;
        m_resp   = '0;
        m_rdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_idx;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                s_req   = sel_req;
                s_addr  = m_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
                s_cmd   = sel_cmd;
                s_wdata = m_wdata[int'(gnt_q)*DATA_W +: DATA_W];
                // A master withdrawing its request abandons the slot without moving the pointer.
                if (!sel_req) begin
                    state_d = IDLE;
                end else if (s_ack) begin
                    m_ack[gnt_q] = 1'b1;
                    if (sel_cmd == CMD_WRITE) begin
                        state_d  = IDLE;
                        rr_ptr_d = wrap_inc(gnt_q);
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end

            WAIT_RESP: begin
                if (s_resp) begin
                    m_resp[gnt_q]                          = 1'b1;
                    m_rdata[int'(gnt_q)*DATA_W +: DATA_W] = s_rdata;
                    state_d                                = IDLE;
                    rr_ptr_d                               = wrap_inc(gnt_q);
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for xbar_slave_arbiter: table-driven transactions with an ack scoreboard, plus contention, drop, reset and 3-master sequences.
module tb_xbar_slave_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      m_req, m_cmd, m_ack, m_resp;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata, m_rdata;
    logic            s_req, s_cmd, s_ack, s_resp;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata;

    logic [2:0]      m_req3, m_cmd3, m_ack3, m_resp3;
    logic [3*AW-1:0] m_addr3;
    logic [3*DW-1:0] m_wdata3, m_rdata3;
    logic            s_req3, s_cmd3, s_ack3, s_resp3;
    logic [AW-1:0]   s_addr3;
    logic [DW-1:0]   s_wdata3, s_rdata3;

    xbar_slave_arbiter #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    xbar_slave_arbiter #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk(clk), .rst(rst),
        .m_req(m_req3), .m_addr(m_addr3), .m_cmd(m_cmd3), .m_wdata(m_wdata3),
        .m_ack(m_ack3), .m_resp(m_resp3), .m_rdata(m_rdata3),
        .s_req(s_req3), .s_addr(s_addr3), .s_cmd(s_cmd3), .s_wdata(s_wdata3),
        .s_ack(s_ack3), .s_resp(s_resp3), .s_rdata(s_rdata3)
    );

    typedef struct {
        int          mst;
        logic [31:0] addr;
        logic        cmd;
        logic [31:0] wdata;
        int          ack_dly;
        int          resp_dly;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        int          mst;
        logic [31:0] addr;
        logic        cmd;
        logic [31:0] wdata;
    } sb_t;

    sb_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted slave transaction must match the oldest expected one.
    always @(negedge clk) begin : sb_mon
        sb_t e;
        if (s_req && s_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: accepted addr %0h, nothing expected", s_addr);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", s_addr, e.addr);
                check("sb_cmd", s_cmd, e.cmd);
                check("sb_wdata", s_wdata, e.wdata);
                check("sb_mack", m_ack, 2'b01 << e.mst);
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int  cnt;
        sb_t e;
        logic [2*DW-1:0] exp_rd;
        m_req[t.mst]               = 1'b1;
        m_cmd[t.mst]               = t.cmd;
        m_addr[t.mst*AW +: AW]     = t.addr;
        m_wdata[t.mst*DW +: DW]    = t.wdata;
        e.mst = t.mst; e.addr = t.addr; e.cmd = t.cmd; e.wdata = t.wdata;
        exp_q.push_back(e);
        #1;
        check("idle_sreq", s_req, 1'b0);
        cnt = 0;
        while (!s_req && cnt < 10) begin
            step();
            #1;
            cnt++;
        end
        check("grant_latency", cnt, 1);
        repeat (t.ack_dly) begin
            check("busy_hold_mack", m_ack, 2'b00);
            step();
            #1;
            check("busy_hold_sreq", s_req, 1'b1);
        end
        s_ack = 1'b1;
        #1;
        check("ack_onehot", m_ack, 2'b01 << t.mst);
        step();
        s_ack        = 1'b0;
        m_req[t.mst] = 1'b0;
        if (t.cmd == 1'b0) begin
            repeat (t.resp_dly - 1) begin
                #1;
                check("wait_sreq", s_req, 1'b0);
                check("wait_addr", s_addr, 32'h0);
                check("wait_mresp", m_resp, 2'b00);
                step();
            end
            s_resp  = 1'b1;
            s_rdata = t.rdata;
            #1;
            exp_rd = '0;
            exp_rd[t.mst*DW +: DW] = t.rdata;
            check("resp_onehot", m_resp, 2'b01 << t.mst);
            check("resp_rdata", m_rdata, exp_rd);
            check("resp_sreq", s_req, 1'b0);
            step();
            s_resp  = 1'b0;
            s_rdata = '0;
        end
    endtask

    txn_t vec[4];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        vec[0] = '{mst: 0, addr: 32'h0000_0010, cmd: 1'b1, wdata: 32'hDEAD_BEEF, ack_dly: 1, resp_dly: 0, rdata: 32'h0};
        vec[1] = '{mst: 1, addr: 32'h0000_0020, cmd: 1'b0, wdata: 32'h0,         ack_dly: 0, resp_dly: 3, rdata: 32'h1234_5678};
        vec[2] = '{mst: 0, addr: 32'h0000_0044, cmd: 1'b0, wdata: 32'h5555_0000, ack_dly: 2, resp_dly: 1, rdata: 32'hA5A5_0F0F};
        vec[3] = '{mst: 1, addr: 32'h0000_0030, cmd: 1'b1, wdata: 32'hCAFE_F00D, ack_dly: 0, resp_dly: 0, rdata: 32'h0};

        rst = 1'b1;
        m_req = 2'b11; m_cmd = 2'b11;
        m_addr = {32'h0000_0204, 32'h0000_0200};
        m_wdata = {32'h0000_0B0B, 32'h0000_0A0A};
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        m_req3 = '0; m_cmd3 = '0; m_addr3 = '0; m_wdata3 = '0;
        s_ack3 = 1'b0; s_resp3 = 1'b0; s_rdata3 = '0;

        // Reset held two cycles with both masters requesting.
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            check("rst_ctrl", {s_req, s_cmd, m_ack, m_resp}, 6'h0);
            check("rst_data", {s_addr, s_wdata}, 64'h0);
            check("rst_rdata", m_rdata, 64'h0);
            check("rst3_sreq", s_req3, 1'b0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_sreq", s_req, 1'b0);
        step();
        #1;
        check("first_sreq", s_req, 1'b1);
        check("first_gnt_m0", s_addr, 32'h0000_0200);
        m_req = 2'b00;
        step();
        m_wdata = '0;

        for (int i = 0; i < 4; i++) run_txn(vec[i]);

        // Contention: both masters stream writes, slave accepts immediately.
        m_req = 2'b11; m_cmd = 2'b11;
        m_addr = {32'h0000_1100, 32'h0000_1000};
        m_wdata = {32'h1111_1111, 32'h0000_0000};
        for (int k = 0; k < 4; k++) begin
            sb_t e;
            e.mst   = k % 2;
            e.addr  = (k % 2) ? 32'h0000_1100 : 32'h0000_1000;
            e.cmd   = 1'b1;
            e.wdata = (k % 2) ? 32'h1111_1111 : 32'h0000_0000;
            exp_q.push_back(e);
        end
        s_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("cont_bubble", s_req, 1'((c % 2) == 1));
            step();
        end
        m_req = 2'b00;
        s_ack = 1'b0;
        #1;
        check("cont_all_acked", exp_q.size(), 0);

        // Request withdrawn before ack: no ack, pointer unchanged.
        m_addr = {32'h0000_0060, 32'h0000_0050};
        m_cmd = 2'b11;
        m_req = 2'b01;
        step();
        #1;
        check("drop_busy", s_req, 1'b1);
        m_req = 2'b00;
        #1;
        check("drop_sreq", s_req, 1'b0);
        check("drop_mack", m_ack, 2'b00);
        step();
        #1;
        check("drop_idle", s_req, 1'b0);
        m_req = 2'b11;
        step();
        #1;
        check("drop_rr_kept", s_addr, 32'h0000_0050);
        m_req = 2'b00;
        step();

        // Reset while waiting for a read response drops it.
        m_cmd = 2'b00;
        m_wdata = '0;
        m_addr = {32'h0000_0070, 32'h0};
        begin
            sb_t e;
            e.mst = 1; e.addr = 32'h0000_0070; e.cmd = 1'b0; e.wdata = 32'h0;
            exp_q.push_back(e);
        end
        m_req = 2'b10;
        step();
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        m_req = 2'b00;
        #1;
        check("wr_sreq", s_req, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_resp = 1'b1;
        s_rdata = 32'hBAD0_BAD0;
        #1;
        check("rst_wr_mresp", m_resp, 2'b00);
        check("rst_wr_rdata", m_rdata, 64'h0);
        check("rst_wr_outs", {s_req, s_addr, m_ack}, 35'h0);
        step();
        s_resp = 1'b0;
        s_rdata = '0;
        #1;
        check("rst_wr_idle", s_req, 1'b0);

        // Three masters: order M0, M1, M2, then pointer wraps to M0.
        m_req3 = 3'b111; m_cmd3 = 3'b111;
        m_addr3 = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        m_wdata3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        s_ack3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] ea;
            ea = 32'h100 * (k + 1);
            step();
            #1;
            check("n3_sreq", s_req3, 1'b1);
            check("n3_addr", s_addr3, ea);
            check("n3_mack", m_ack3, 3'b001 << k);
            step();
            m_req3[k] = 1'b0;
            #1;
            check("n3_bubble", s_req3, 1'b0);
        end
        m_req3 = 3'b111;
        step();
        #1;
        check("n3_wrap", s_addr3, 32'h0000_0100);
        s_ack3 = 1'b0;
        m_req3 = 3'b000;
        step();

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
